// File: rtl/rf_write_arbiter_if.sv
// Register-file write port bundle shared by the MEM/WB stage, the long-latency unit and the arbiter.
// Handshake: a long-latency result transfers on a rising edge where lat_valid_i && lat_ready_o; the source holds it until then.
interface rf_write_arbiter_if;
  logic        pipe_we_i;
  logic [4:0]  pipe_addr_i;
  logic [31:0] pipe_data_i;
  logic        lat_valid_i;
  logic [4:0]  lat_addr_i;
  logic [31:0] lat_data_i;
  logic        lat_ready_o;
  logic        stall_o;
  logic        RegWrite_o;
  logic [4:0]  RegWaddr_o;
  logic [31:0] RegWdata_o;
  logic        dbg_state;
  logic [1:0]  dbg_count;
  logic [3:0]  dbg_age;

  modport master (
    output pipe_we_i, pipe_addr_i, pipe_data_i, lat_valid_i, lat_addr_i, lat_data_i,
    input  lat_ready_o, stall_o, RegWrite_o, RegWaddr_o, RegWdata_o,
    input  dbg_state, dbg_count, dbg_age
  );

  modport slave (
    input  pipe_we_i, pipe_addr_i, pipe_data_i, lat_valid_i, lat_addr_i, lat_data_i,
    output lat_ready_o, stall_o, RegWrite_o, RegWaddr_o, RegWdata_o,
    output dbg_state, dbg_count, dbg_age
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between MEM/WB writebacks and a 2-deep
// buffer of long-latency results, forcing a one-cycle pipeline stall when a buffered result starves.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk_i,
  input logic               start_i,
  rf_write_arbiter_if.slave bus
);

  typedef enum logic {NORMAL = 1'b0, STALL = 1'b1} state_t;

  state_t      state_q, state_next;
  logic [1:0]  count_q, count_next;
  logic [3:0]  age_q, age_next;
  logic        rd_ptr_q, wr_ptr_q;
  logic [4:0]  mem_addr_q [2];
  logic [31:0] mem_data_q [2];

  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        lat_ready, push, pop, grant_pipe;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  always_comb begin
    lat_ready  = start_i && (count_q != 2'd2);
    push       = bus.lat_valid_i && lat_ready;
    pop        = 1'b0;
    grant_pipe = 1'b0;
    // The pipeline is never written while stalled: it re-presents the same request next cycle.
    if (state_q == STALL && count_q != 2'd0) begin
      pop = 1'b1;
    end else if (state_q == NORMAL && bus.pipe_we_i) begin
      grant_pipe = 1'b1;
    end else if (count_q != 2'd0) begin
      pop = 1'b1;
    end

    sel_addr = pop ? mem_addr_q[rd_ptr_q] : bus.pipe_addr_i;
    sel_data = pop ? mem_data_q[rd_ptr_q] : bus.pipe_data_i;

    count_next = count_q + {1'b0, push} - {1'b0, pop};

    if (count_q == 2'd0 || pop) begin
      age_next = 4'd0;
    end else if (age_q < 4'(STARVE_LIMIT)) begin
      age_next = age_q + 4'd1;
    end else begin
      age_next = age_q;
    end

    state_next = NORMAL;
    if (state_q == NORMAL && count_q != 2'd0 && !pop && age_q == 4'(STARVE_LIMIT - 1)) begin
      state_next = STALL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_q  <= NORMAL;
      count_q  <= 2'd0;
      age_q    <= 4'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q <= state_next;
      count_q <= count_next;
      age_q   <= age_next;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      // A granted write to r0 still consumes its slot but never reaches the register file.
      if ((pop || grant_pipe) && sel_addr != 5'd0) begin
        we_q    <= 1'b1;
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end else begin
        we_q    <= 1'b0;
        waddr_q <= 5'd0;
        wdata_q <= 32'd0;
      end
    end
  end

  // Buffer storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= bus.lat_addr_i;
      mem_data_q[wr_ptr_q] <= bus.lat_data_i;
    end
  end

  assign bus.lat_ready_o = lat_ready;
  assign bus.stall_o     = (state_q == STALL);
  assign bus.RegWrite_o  = we_q;
  assign bus.RegWaddr_o  = waddr_q;
  assign bus.RegWdata_o  = wdata_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_count   = count_q;
  assign bus.dbg_age     = age_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with STARVE_LIMIT=4: a per-cycle vector table plus
// hand sequences for push/pop at count 1 and reset during a stall with a full buffer.
module tb_rf_write_arbiter;

  logic clk_i = 1'b0;
  logic start_i;
  int   checks = 0;
  int   errors = 0;
  logic [36:0] exp_q [$];

  rf_write_arbiter_if bus();

  rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i  (clk_i),
    .start_i(start_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        st;
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        rdy;
    logic        stall;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  cnt;
    logic [3:0]  age;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.pipe_we_i   = pwe;
    bus.pipe_addr_i = pa;
    bus.pipe_data_i = pd;
    bus.lat_valid_i = lv;
    bus.lat_addr_i  = la;
    bus.lat_data_i  = ld;
  endtask

  initial begin
    // Rows: st pwe pa pd lv la ld | rdy stall we wa wd cnt age (outputs as seen during that cycle)
    vecs[0]  = '{1, 1, 5, 32'h1234,     0, 0,  0,          1, 0, 0, 0,  0,          0, 0};
    vecs[1]  = '{1, 0, 0, 0,            1, 7,  32'hAA,     1, 0, 1, 5,  32'h1234,   0, 0};
    vecs[2]  = '{1, 0, 0, 0,            0, 0,  0,          1, 0, 0, 0,  0,          1, 0};
    vecs[3]  = '{1, 0, 0, 0,            0, 0,  0,          1, 0, 1, 7,  32'hAA,     0, 0};
    vecs[4]  = '{1, 1, 3, 32'h33,       1, 8,  32'h88,     1, 0, 0, 0,  0,          0, 0};
    vecs[5]  = '{1, 1, 3, 32'h33,       1, 9,  32'h99,     1, 0, 1, 3,  32'h33,     1, 0};
    vecs[6]  = '{1, 1, 3, 32'h33,       1, 10, 32'hAAA,    0, 0, 1, 3,  32'h33,     2, 1};
    vecs[7]  = '{1, 1, 3, 32'h33,       1, 10, 32'hAAA,    0, 0, 1, 3,  32'h33,     2, 2};
    vecs[8]  = '{1, 1, 3, 32'h33,       1, 10, 32'hAAA,    0, 0, 1, 3,  32'h33,     2, 3};
    vecs[9]  = '{1, 1, 3, 32'h33,       1, 10, 32'hAAA,    0, 1, 1, 3,  32'h33,     2, 4};
    vecs[10] = '{1, 1, 3, 32'h33,       1, 10, 32'hAAA,    1, 0, 1, 8,  32'h88,     1, 0};
    vecs[11] = '{1, 1, 3, 32'h33,       0, 0,  0,          0, 0, 1, 3,  32'h33,     2, 1};
    vecs[12] = '{1, 0, 0, 0,            0, 0,  0,          0, 0, 1, 3,  32'h33,     2, 2};
    vecs[13] = '{1, 0, 0, 0,            0, 0,  0,          1, 0, 1, 9,  32'h99,     1, 0};
    vecs[14] = '{1, 1, 0, 32'hFFFFFFFF, 0, 0,  0,          1, 0, 1, 10, 32'hAAA,    0, 0};
    vecs[15] = '{1, 1, 0, 32'hFFFFFFFF, 0, 0,  0,          1, 0, 0, 0,  0,          0, 0};
    vecs[16] = '{1, 0, 0, 0,            1, 0,  32'hDEAD,   1, 0, 0, 0,  0,          0, 0};
    vecs[17] = '{1, 0, 0, 0,            0, 0,  0,          1, 0, 0, 0,  0,          1, 0};
    vecs[18] = '{1, 0, 0, 0,            0, 0,  0,          1, 0, 0, 0,  0,          0, 0};

    // Clock/reset
    start_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_lat_ready", bus.lat_ready_o, 0);
    check("rst_regwrite", bus.RegWrite_o, 0);
    check("rst_stall", bus.stall_o, 0);

    // Vector table
    for (int i = 0; i < 19; i++) begin
      start_i = vecs[i].st;
      drive(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
      #1;
      check($sformatf("v%0d_lat_ready", i), bus.lat_ready_o, vecs[i].rdy);
      check($sformatf("v%0d_stall", i), bus.stall_o, vecs[i].stall);
      check($sformatf("v%0d_regwrite", i), bus.RegWrite_o, vecs[i].we);
      check($sformatf("v%0d_waddr", i), bus.RegWaddr_o, vecs[i].wa);
      check($sformatf("v%0d_wdata", i), bus.RegWdata_o, vecs[i].wd);
      check($sformatf("v%0d_count", i), bus.dbg_count, vecs[i].cnt);
      check($sformatf("v%0d_age", i), bus.dbg_age, vecs[i].age);
      step();
    end

    // Push and pop together at count 1 keep count at 1; results leave in order.
    drive(0, 0, 0, 1, 1, 32'h11);
    exp_q.push_back({5'd1, 32'h11});
    step();
    drive(0, 0, 0, 1, 2, 32'h22);
    exp_q.push_back({5'd2, 32'h22});
    #1;
    check("pp_count_a", bus.dbg_count, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("pp_count_b", bus.dbg_count, 1);
    check("pp_we_a", bus.RegWrite_o, 1);
    check("pp_order_a", {bus.RegWaddr_o, bus.RegWdata_o}, exp_q.pop_front());
    step();
    check("pp_count_c", bus.dbg_count, 0);
    check("pp_we_b", bus.RegWrite_o, 1);
    check("pp_order_b", {bus.RegWaddr_o, bus.RegWdata_o}, exp_q.pop_front());
    step();
    check("pp_idle", bus.RegWrite_o, 0);

    // Fill the buffer behind a busy pipeline, reach STALL, then reset for one cycle.
    drive(1, 4, 32'h44, 1, 11, 32'h111);
    step();
    drive(1, 4, 32'h44, 1, 12, 32'h112);
    step();
    drive(1, 4, 32'h44, 0, 0, 0);
    #1;
    for (int i = 0; i < 12 && bus.stall_o !== 1'b1; i++) step();
    check("rs_stall_reached", bus.stall_o, 1);
    check("rs_full", bus.dbg_count, 2);
    start_i = 1'b0;
    drive(0, 0, 0, 1, 13, 32'h113);
    #1;
    check("rs_ready_low", bus.lat_ready_o, 0);
    step();
    check("rs_count", bus.dbg_count, 0);
    check("rs_age", bus.dbg_age, 0);
    check("rs_stall", bus.stall_o, 0);
    check("rs_regwrite", bus.RegWrite_o, 0);
    check("rs_waddr", bus.RegWaddr_o, 0);
    check("rs_wdata", bus.RegWdata_o, 0);
    start_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("rs_ready_back", bus.lat_ready_o, 1);
    step();
    step();
    check("rs_dropped", bus.RegWrite_o, 0);
    check("rs_empty", bus.dbg_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4 (range 2..15), max cycles a buffered long-latency result waits behind pipeline writebacks before a forced drain.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 start_i  input  1  reset, synchronous, active-low.
REQ-004 pipe_we_i  input  1  writeback request from the MEM/WB stage (its RegWrite).
REQ-005 pipe_addr_i  input  5  writeback destination register from the MEM/WB stage.
REQ-006 pipe_data_i  input  32  writeback data, already MemtoReg-selected.
REQ-007 lat_valid_i  input  1  long-latency unit result valid.
REQ-008 lat_addr_i  input  5  long-latency result destination register.
REQ-009 lat_data_i  input  32  long-latency result data.
REQ-010 lat_ready_o  output  1  buffer can accept a result this cycle.
REQ-011 stall_o  output  1  pipeline shall hold MEM/WB and re-present its request next cycle.
REQ-012 RegWrite_o  output  1  register-file write enable, registered.
REQ-013 RegWaddr_o  output  5  register-file write address, registered.
REQ-014 RegWdata_o  output  32  register-file write data, registered.

Function
REQ-015 Two-entry FIFO of {addr, data} buffers long-latency results; count 0..2; in-order.
REQ-016 lat_ready_o = (count < 2) and start_i high; push when lat_valid_i and lat_ready_o.
REQ-017 Only entries present at cycle start are poppable; push-to-pop minimum is one cycle, no bypass.
REQ-018 Grant per cycle, in priority order: state STALL with count>0 -> FIFO head; pipe_we_i -> pipeline; count>0 -> FIFO head; else none.
REQ-019 Push and pop in the same cycle at count 1 leave count 1; at count 0 push gives count 1.
REQ-020 Output latency one cycle: the granted source's addr/data register onto RegWaddr_o/RegWdata_o, RegWrite_o=1.
REQ-021 No grant: RegWrite_o=0, RegWaddr_o=0, RegWdata_o=0.
REQ-022 Granted addr 0: slot consumed (pipeline accepted or FIFO popped) but RegWrite_o=0, RegWaddr_o=0, RegWdata_o=0.
REQ-023 Age counter (4 bits): 0 when count==0 or head popped; else increments each cycle the head is not popped, saturating at STARVE_LIMIT.
REQ-024 States NORMAL, STALL; NORMAL -> STALL when age==STARVE_LIMIT-1 and head not popped this cycle; STALL -> NORMAL after one cycle (head always popped in STALL).
REQ-025 stall_o = (state==STALL), registered; in STALL the pipeline request is not written and must be re-presented.
REQ-026 WAW ordering between pipeline and buffered results is not this block's concern; the issue scoreboard prevents it.

Reset
REQ-027 start_i low at a rising edge: count=0, age=0, state=NORMAL, FIFO entries discarded, RegWrite_o=0, RegWaddr_o=0, RegWdata_o=0, stall_o=0.
REQ-028 While start_i low: lat_ready_o=0, all inputs ignored; reset mid-STALL or with full FIFO drops pending results.

Verification (STARVE_LIMIT=4)
REQ-029 Reset, then pipe_we_i=1, addr 5, data 0x00001234 in cycle 0 -> cycle 1: RegWrite_o=1, RegWaddr_o=5, RegWdata_o=0x00001234.
REQ-030 pipe idle, lat push addr 7, data 0x000000AA in cycle 0 -> popped cycle 1; cycle 2: RegWrite_o=1, RegWaddr_o=7, RegWdata_o=0xAA.
REQ-031 pipe_we_i held 1, lat pushes in cycles 0, 1 -> lat_ready_o=0 from cycle 2; third result held by source, accepted only after a pop.
REQ-032 pipe_we_i held 1, one entry pushed cycle 0 -> age 1..3 in cycles 2..4; stall_o=1 in cycle 5 only; FIFO entry on outputs cycle 6; pipeline write resumes, on outputs cycle 7.
REQ-033 pipe_we_i=1, addr 0, data 0xFFFFFFFF -> RegWrite_o stays 0, outputs 0, no stall.
REQ-034 Full FIFO in STALL, start_i low one cycle -> next cycle: count=0, stall_o=0, RegWrite_o=0; lat_ready_o=1 once start_i high.
